// File: rtl/fp_mul_booth_iter.sv
// rtl/fp_mul_booth_iter.sv - iterative radix-4 Booth FP significand multiplier with carry-save output
//
// Purpose: multiplies two IEEE-754 operands of format (EWIDTH, MWIDTH) and emits
// sign, unbiased exponent sum and the significand product as a sum/carry pair
// whose modulo-2^PW sum equals sigA*sigB. PP_PER_CYCLE Booth partial products
// are compressed per cycle, so a result takes NITER cycles after acceptance.
//
// Ports:
//   clk, rstn                 clock (rising edge), asynchronous active-low reset
//   i_valid / o_ready         operand handshake (a_operand, b_operand)
//   o_valid / i_ready         result handshake
//   o_sign                    sign(A) xor sign(B)
//   o_sum, o_carry            carry-save significand product (PW bits)
//   o_exponent                signed eA+eB (EWIDTH+1 bits)
//   o_zero, o_inf, o_nan      special-value classification
//
// Option macro FP_MUL_BOOTH_SUBNORM_EN: when defined, exponent field 0 with a
// non-zero mantissa is treated as subnormal; otherwise it is flushed to zero.

module fp_mul_booth_iter #(
    parameter int DWIDTH       = 16,
    parameter int EWIDTH       = 5,
    parameter int MWIDTH       = 10,
    parameter int PP_PER_CYCLE = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [DWIDTH-1:0]    a_operand,
    input  logic [DWIDTH-1:0]    b_operand,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_sign,
    output logic [2*MWIDTH+1:0]  o_sum,
    output logic [2*MWIDTH+1:0]  o_carry,
    output logic [EWIDTH:0]      o_exponent,
    output logic                 o_zero,
    output logic                 o_inf,
    output logic                 o_nan
);

    localparam int PW    = 2*MWIDTH + 2;
    localparam int NPP   = (MWIDTH + 1)/2 + 1;
    localparam int NITER = (NPP + PP_PER_CYCLE - 1)/PP_PER_CYCLE;
    localparam int BW    = 2*NPP + 1;              // multiplier plus the implicit y[-1] bit
    localparam int CW    = $clog2(NITER + 1);
    localparam int SH    = 2*PP_PER_CYCLE;
    localparam logic [EWIDTH:0] BIAS2 = (EWIDTH+1)'(2**EWIDTH - 2);   // 2*BIAS

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       iter_q, iter_d;
    logic                sign_q, sign_d, zero_q, zero_d, inf_q, inf_d, nan_q, nan_d;
    logic [EWIDTH:0]     exp_q, exp_d;
    logic [PW-1:0]       sum_q, sum_d, carry_q, carry_d;
    logic [PW-1:0]       mcand_q, mcand_d;         // sigA pre-shifted to the current digit group
    logic [BW-1:0]       mpl_q, mpl_d;             // Booth multiplier, consumed from the bottom
    logic [PW-1:0]       pos_q, pos_d;             // one-hot weight of the current group's first digit
    logic [PW-1:0]       msk_q, msk_d;             // all bits below pos_q

    // Operand decode
    logic [EWIDTH-1:0]   ea_f, eb_f, efa, efb;
    logic [MWIDTH-1:0]   ma_f, mb_f;
    logic [MWIDTH:0]     sig_a, sig_b;
    logic                emax_a, emax_b, ezero_a, ezero_b, mzero_a, mzero_b;
    logic                zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic                special, nan_w, inf_w, zero_w;
    logic [EWIDTH:0]     exp_w;

    assign ea_f    = a_operand[DWIDTH-2 -: EWIDTH];
    assign eb_f    = b_operand[DWIDTH-2 -: EWIDTH];
    assign ma_f    = a_operand[MWIDTH-1:0];
    assign mb_f    = b_operand[MWIDTH-1:0];
    assign emax_a  = &ea_f;
    assign emax_b  = &eb_f;
    assign ezero_a = ~|ea_f;
    assign ezero_b = ~|eb_f;
    assign mzero_a = ~|ma_f;
    assign mzero_b = ~|mb_f;

`ifdef FP_MUL_BOOTH_SUBNORM_EN
    assign zero_a = ezero_a & mzero_a;
    assign zero_b = ezero_b & mzero_b;
    assign sig_a  = {~ezero_a, ma_f};
    assign sig_b  = {~ezero_b, mb_f};
    assign efa    = ezero_a ? EWIDTH'(1) : ea_f;   // subnormal exponent is 1-BIAS
    assign efb    = ezero_b ? EWIDTH'(1) : eb_f;
`else
    assign zero_a = ezero_a;
    assign zero_b = ezero_b;
    assign sig_a  = {1'b1, ma_f};
    assign sig_b  = {1'b1, mb_f};
    assign efa    = ea_f;
    assign efb    = eb_f;
`endif

    assign inf_a   = emax_a & mzero_a;
    assign inf_b   = emax_b & mzero_b;
    assign nan_a   = emax_a & ~mzero_a;
    assign nan_b   = emax_b & ~mzero_b;
    assign nan_w   = nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a);
    assign inf_w   = (inf_a | inf_b) & ~nan_w;
    assign zero_w  = (zero_a | zero_b) & ~nan_w;
    assign special = zero_a | zero_b | emax_a | emax_b;
    assign exp_w   = {1'b0, efa} + {1'b0, efb} - BIAS2;

    function automatic logic [2*PW-1:0] csa(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                            input logic [PW-1:0] z);
        return {x ^ y ^ z, ((x & y) | (x & z) | (y & z)) << 1};
    endfunction

    // One iteration of the carry-save tree: PP_PER_CYCLE Booth partial products
    // plus a correction word holding the +1 of every negative digit. A negative
    // digit's PP is ~mag with the always-zero low bits cleared, so its +1 lands
    // exactly at the digit weight and corrections of different digits never collide.
    logic [PW-1:0] s_w, c_w, corr_w, mc_k, onehot_k, mask_k, mag_k, pp_k;
    logic [2:0]    trip_k;
    logic          neg_k, one_k, two_k;

    always_comb begin
        s_w      = sum_q;
        c_w      = carry_q;
        corr_w   = '0;
        mc_k     = '0;
        onehot_k = '0;
        mask_k   = '0;
        mag_k    = '0;
        pp_k     = '0;
        trip_k   = '0;
        neg_k    = 1'b0;
        one_k    = 1'b0;
        two_k    = 1'b0;
        for (int k = 0; k < PP_PER_CYCLE; k++) begin
            trip_k   = mpl_q[2*k +: 3];
            neg_k    = trip_k[2] & ~(trip_k[1] & trip_k[0]);
            one_k    = trip_k[1] ^ trip_k[0];
            two_k    = (trip_k == 3'b100) | (trip_k == 3'b011);
            mc_k     = mcand_q << (2*k);
            onehot_k = pos_q << (2*k);
            mask_k   = ~((~msk_q) << (2*k));
            mag_k    = one_k ? mc_k : (two_k ? (mc_k << 1) : '0);
            pp_k     = neg_k ? (~mag_k & ~mask_k) : mag_k;
            corr_w   = corr_w | (neg_k ? onehot_k : '0);
            {s_w, c_w} = csa(s_w, c_w, pp_k);
        end
        {s_w, c_w} = csa(s_w, c_w, corr_w);
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        sign_d  = sign_q;
        zero_d  = zero_q;
        inf_d   = inf_q;
        nan_d   = nan_q;
        exp_d   = exp_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        mcand_d = mcand_q;
        mpl_d   = mpl_q;
        pos_d   = pos_q;
        msk_d   = msk_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    state_d = RUN;
                    iter_d  = '0;
                    sign_d  = a_operand[DWIDTH-1] ^ b_operand[DWIDTH-1];
                    zero_d  = zero_w;
                    inf_d   = inf_w;
                    nan_d   = nan_w;
                    // Zeroed significands make every digit 0, so sum and carry stay exactly 0.
                    exp_d   = special ? '0 : exp_w;
                    mcand_d = special ? '0 : PW'(sig_a);
                    mpl_d   = special ? '0 : BW'({sig_b, 1'b0});
                    sum_d   = '0;
                    carry_d = '0;
                    pos_d   = PW'(1);
                    msk_d   = '0;
                end
            end
            RUN: begin
                sum_d   = s_w;
                carry_d = c_w;
                mcand_d = mcand_q << SH;
                mpl_d   = mpl_q >> SH;
                pos_d   = pos_q << SH;
                msk_d   = ~((~msk_q) << SH);
                iter_d  = iter_q + CW'(1);
                if (iter_q == CW'(NITER - 1)) begin
                    state_d = DONE;
                    iter_d  = '0;
                end
            end
            DONE: begin
                if (i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            iter_q  <= '0;
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
            inf_q   <= 1'b0;
            nan_q   <= 1'b0;
            exp_q   <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            mcand_q <= '0;
            mpl_q   <= '0;
            pos_q   <= '0;
            msk_q   <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            sign_q  <= sign_d;
            zero_q  <= zero_d;
            inf_q   <= inf_d;
            nan_q   <= nan_d;
            exp_q   <= exp_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            mcand_q <= mcand_d;
            mpl_q   <= mpl_d;
            pos_q   <= pos_d;
            msk_q   <= msk_d;
        end
    end

    assign o_ready    = (state_q == IDLE);
    assign o_valid    = (state_q == DONE);
    assign o_sign     = sign_q;
    assign o_sum      = sum_q;
    assign o_carry    = carry_q;
    assign o_exponent = exp_q;
    assign o_zero     = zero_q;
    assign o_inf      = inf_q;
    assign o_nan      = nan_q;

endmodule

// File: tb/tb_fp_mul_booth_iter.sv
// tb/tb_fp_mul_booth_iter.sv - directed self-checking bench for fp_mul_booth_iter (FP16 defaults)

module tb_fp_mul_booth_iter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_valid, i_ready;
    logic [15:0] a_op, b_op;
    logic        o_ready, o_valid, o_sign, o_zero, o_inf, o_nan;
    logic [21:0] o_sum, o_carry;
    logic [5:0]  o_exponent;

    int tests_run    = 0;
    int tests_failed = 0;

    fp_mul_booth_iter dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .a_operand  (a_op),
        .b_operand  (b_op),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_sign     (o_sign),
        .o_sum      (o_sum),
        .o_carry    (o_carry),
        .o_exponent (o_exponent),
        .o_zero     (o_zero),
        .o_inf      (o_inf),
        .o_nan      (o_nan)
    );

    always #5 clk = ~clk;

    // Presents one operand pair, waits for acceptance, returns cycles from the
    // accepting edge until o_valid (negative on timeout). Leaves the result unacknowledged.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y, output int lat);
        int n;
        @(posedge clk); #1;
        a_op = x; b_op = y; i_valid = 1'b1;
        n = 0;
        while (!o_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        if (!o_valid) lat = -1;
        if (n >= 20) lat = -2;
    endtask

    task automatic ack();
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; i_valid = 1'b0; i_ready = 1'b0; a_op = '0; b_op = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (o_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
        tests_run++;
        if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        tests_run++;
        if ({o_sum, o_carry} !== 44'd0) begin tests_failed++; $display("FAIL reset_data: sum %h carry %h expected 0", o_sum, o_carry); end
        tests_run++;
        if ({o_sign, o_exponent, o_zero, o_inf, o_nan} !== 10'd0) begin
            tests_failed++;
            $display("FAIL reset_flags: sign %b exp %h z/i/n %b%b%b expected all 0", o_sign, o_exponent, o_zero, o_inf, o_nan);
        end
        rstn = 1'b1;
    endtask

    task automatic test_directed();
        logic [15:0] va [13];
        logic [15:0] vb [13];
        logic        vs [13];
        logic [5:0]  ve [13];
        logic [21:0] vp [13];
        logic [2:0]  vf [13];   // {zero, inf, nan}
        logic [21:0] psum;
        int          lat;
        va = '{16'h3C00, 16'h4000, 16'h0001, 16'h7C00, 16'h7C00, 16'h7E00, 16'h3FFF,
               16'h7BFF, 16'h0400, 16'h5555, 16'h8000, 16'h0000, 16'h7C00};
        vb = '{16'h3C00, 16'hC200, 16'h3C00, 16'h3C00, 16'h0000, 16'hC500, 16'h3FFF,
               16'h7BFF, 16'h0400, 16'hAAAA, 16'h4000, 16'hFC00, 16'hFC00};
        vs = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        ve = '{6'h00, 6'h02, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h1E, 6'h24, 6'h01, 6'h00, 6'h00, 6'h00};
        vp = '{22'h100000, 22'h180000, 22'h0, 22'h0, 22'h0, 22'h0, 22'h3FF001,
               22'h3FF001, 22'h100000, 22'h238872, 22'h0, 22'h0, 22'h0};
        vf = '{3'b000, 3'b000, 3'b100, 3'b010, 3'b001, 3'b001, 3'b000,
               3'b000, 3'b000, 3'b000, 3'b100, 3'b001, 3'b010};
`ifdef FP_MUL_BOOTH_SUBNORM_EN
        ve[2] = 6'h32;          // -14
        vp[2] = 22'h000400;
        vf[2] = 3'b000;
`endif
        for (int i = 0; i < 13; i++) begin
            run_op(va[i], vb[i], lat);
            psum = o_sum + o_carry;
            tests_run++;
            if (lat !== 3) begin tests_failed++; $display("FAIL latency[%0d]: got %0d expected 3", i, lat); end
            tests_run++;
            if (o_sign !== vs[i]) begin tests_failed++; $display("FAIL sign[%0d]: got %b expected %b", i, o_sign, vs[i]); end
            tests_run++;
            if (o_exponent !== ve[i]) begin tests_failed++; $display("FAIL exponent[%0d]: got %h expected %h", i, o_exponent, ve[i]); end
            tests_run++;
            if (psum !== vp[i]) begin tests_failed++; $display("FAIL product[%0d]: got %h expected %h", i, psum, vp[i]); end
            tests_run++;
            if ({o_zero, o_inf, o_nan} !== vf[i]) begin
                tests_failed++;
                $display("FAIL flags[%0d]: got %b%b%b expected %b", i, o_zero, o_inf, o_nan, vf[i]);
            end
            if (vf[i] != 3'b000) begin
                tests_run++;
                if ({o_sum, o_carry} !== 44'd0) begin
                    tests_failed++;
                    $display("FAIL special_zero_cs[%0d]: sum %h carry %h expected 0", i, o_sum, o_carry);
                end
            end
            ack();
            tests_run++;
            if ({o_valid, o_ready} !== 2'b01) begin
                tests_failed++;
                $display("FAIL post_ack[%0d]: valid/ready %b%b expected 01", i, o_valid, o_ready);
            end
        end
    endtask

    task automatic test_hold();
        logic [21:0] psum;
        int          lat;
        run_op(16'h3E00, 16'h4100, lat);
        tests_run++;
        if (lat !== 3) begin tests_failed++; $display("FAIL hold_latency: got %0d expected 3", lat); end
        a_op = 16'h3C00; b_op = 16'h3C00; i_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            psum = o_sum + o_carry;
            tests_run++;
            if ({o_valid, o_ready} !== 2'b10) begin
                tests_failed++;
                $display("FAIL hold_handshake[%0d]: valid/ready %b%b expected 10", c, o_valid, o_ready);
            end
            tests_run++;
            if (psum !== 22'h1E0000 || o_exponent !== 6'h01) begin
                tests_failed++;
                $display("FAIL hold_data[%0d]: product %h exp %h expected 1e0000 01", c, psum, o_exponent);
            end
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if ({o_valid, o_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL hold_release: valid/ready %b%b expected 01", o_valid, o_ready);
        end
        @(posedge clk); #1;
        tests_run++;
        if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL hold_single_handshake: valid %b expected 0", o_valid); end
        i_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [21:0] psum;
        int          lat;
        @(posedge clk); #1;
        a_op = 16'h4000; b_op = 16'h4000; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        tests_run++;
        if ({o_valid, o_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL abort_async: valid/ready %b%b expected 01", o_valid, o_ready);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            tests_run++;
            if ({o_valid, o_ready} !== 2'b01) begin
                tests_failed++;
                $display("FAIL abort_no_result[%0d]: valid/ready %b%b expected 01", c, o_valid, o_ready);
            end
        end
        run_op(16'h3C00, 16'h3C00, lat);
        psum = o_sum + o_carry;
        tests_run++;
        if (lat !== 3) begin tests_failed++; $display("FAIL abort_next_latency: got %0d expected 3", lat); end
        tests_run++;
        if (psum !== 22'h100000 || o_exponent !== 6'h00 || o_sign !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_next_result: product %h exp %h sign %b expected 100000 00 0", psum, o_exponent, o_sign);
        end
        ack();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
